// File: rtl/pattern_serializer_pkg.sv
// Shared state encoding and load-length clamp for the pattern serializer.
// Build option PATTERN_SERIALIZER_PRESCALE_EN is handled in the top and divider files.
package pattern_serializer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    function automatic int clamp_len(input int len, input int width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Load handshake between the host command decoder and the pattern serializer.
interface pattern_serializer_if #(
    parameter int WIDTH = 64,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int REP_W = 8
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             load_lsb_first;
    logic [REP_W-1:0] load_repeat;

    modport master (
        output load_valid,
        output load_data,
        output load_len,
        output load_lsb_first,
        output load_repeat,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_len,
        input  load_lsb_first,
        input  load_repeat,
        output load_ready
    );

endinterface

// File: rtl/pattern_serializer_bit_rate_divider.sv
// Bit-rate prescaler: bit_tick fires once every div+1 cycles, restarted at each load.
// Only present when PATTERN_SERIALIZER_PRESCALE_EN is defined.
`ifdef PATTERN_SERIALIZER_PRESCALE_EN
module bit_rate_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // Down-counter with terminal-count compare; restart loads the fresh divisor
    // so the first bit is held as long as every other bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (restart) begin
            div_q <= div;
            cnt_q <= div;
        end else if (cnt_q == '0) begin
            cnt_q <= div_q;
        end else begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign bit_tick = (cnt_q == '0);

endmodule
`endif

// File: rtl/pattern_serializer.sv
// Glitch-waveform serializer: plays the first load_len bits of a pattern, repeated load_repeat times.
// Define PATTERN_SERIALIZER_PRESCALE_EN to hold each bit for bit_div+1 cycles.
//
// state | meaning
// IDLE  | waiting for a load; out=0, busy=0
// SHIFT | emitting pattern bits, out_valid=1
// DONE  | one-cycle done pulse, busy=1
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int REP_W = 8
`ifdef PATTERN_SERIALIZER_PRESCALE_EN
    ,
    parameter int DIV_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pattern_serializer_if.slave  load,
    input  logic                 abort,
`ifdef PATTERN_SERIALIZER_PRESCALE_EN
    input  logic [DIV_W-1:0]     bit_div,
`endif
    output logic                 out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             lsb_q, lsb_d;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] idx_d;
    logic             load_fire;
    logic             last_bit;
    logic             bit_tick;
    logic             out_q, out_d;

    assign load.load_ready = (state_q == IDLE) && !abort && rst_n;
    assign load_fire       = load.load_valid && load.load_ready;
    assign len_clamped     = LEN_W'(clamp_len(int'(load.load_len), WIDTH));
    assign last_bit        = (bit_cnt_q == len_q - LEN_W'(1));

`ifdef PATTERN_SERIALIZER_PRESCALE_EN
    bit_rate_divider #(
        .DIV_W (DIV_W)
    ) u_bit_rate_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load_fire),
        .div      (bit_div),
        .bit_tick (bit_tick)
    );
`else
    assign bit_tick = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        lsb_d     = lsb_q;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    data_d    = load.load_data;
                    len_d     = len_clamped;
                    lsb_d     = load.load_lsb_first;
                    rep_d     = load.load_repeat;
                    bit_cnt_d = '0;
                    state_d   = (len_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_tick) begin
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    end else if (rep_q != '0) begin
                        // Wrap straight into the next repeat so there is no idle gap.
                        rep_d     = rep_q - REP_W'(1);
                        bit_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output bit is registered from next-state values so out lines up with out_valid.
    always_comb begin
        idx_d = lsb_d ? bit_cnt_d : (len_d - LEN_W'(1) - bit_cnt_d);
        out_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_d == LEN_W'(i)) out_d = data_d[i];
        end
        if (state_d != SHIFT) out_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            lsb_q     <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            lsb_q     <= lsb_d;
            out_q     <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer with a bit scoreboard fed from a reference model.
module tb_pattern_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic out, out_valid, busy, done;
`ifdef PATTERN_SERIALIZER_PRESCALE_EN
    logic [15:0] bit_div = 16'd0;
`endif

    pattern_serializer_if #(.WIDTH(64), .LEN_W(7), .REP_W(8)) ifc ();

    pattern_serializer #(
        .WIDTH (64),
        .LEN_W (7),
        .REP_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifc),
        .abort     (abort),
`ifdef PATTERN_SERIALIZER_PRESCALE_EN
        .bit_div   (bit_div),
`endif
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   valid_cnt = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Scoreboard: every out_valid cycle consumes one predicted bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                valid_cnt++;
                chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("sb_bit", 64'(out), 64'(exp_q.pop_front()));
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_exp(input logic [63:0] data, input int len, input logic lsb,
                            input int rep, input int limit);
        int l = (len > 64) ? 64 : len;
        int n = 0;
        for (int r = 0; r <= rep; r++)
            for (int i = 0; i < l; i++)
                if (n < limit) begin
                    exp_q.push_back(data[lsb ? i : l - 1 - i]);
                    n++;
                end
    endtask

    // Called just after a negedge; returns just after the first negedge following acceptance.
    task automatic accept(input logic [63:0] data, input int len, input logic lsb,
                          input int rep, input string tag);
        ifc.load_valid     = 1'b1;
        ifc.load_data      = data;
        ifc.load_len       = 7'(len);
        ifc.load_lsb_first = lsb;
        ifc.load_repeat    = 8'(rep);
        #1;
        chk({tag, "_ready"}, 64'(ifc.load_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ifc.load_valid = 1'b0;
        ifc.load_data  = ~data;
    endtask

    task automatic run(input logic [63:0] data, input int len, input logic lsb,
                       input int rep, input string tag);
        int l        = (len > 64) ? 64 : len;
        int exp_done = l * (rep + 1) + 1;
        int got      = -1;
        int v0, d0;
        push_exp(data, len, lsb, rep, 1 << 30);
        v0 = valid_cnt;
        d0 = done_cnt;
        accept(data, len, lsb, rep, tag);
        for (int k = 1; k <= exp_done + 5; k++) begin
            if (done) begin
                got = k;
                chk({tag, "_ready_in_done"}, 64'(ifc.load_ready), 64'd0);
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_cycle"}, 64'(got), 64'(exp_done));
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_valid_cycles"}, 64'(valid_cnt - v0), 64'(l * (rep + 1)));
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        ifc.load_valid     = 1'b0;
        ifc.load_data      = '0;
        ifc.load_len       = '0;
        ifc.load_lsb_first = 1'b0;
        ifc.load_repeat    = '0;

        #12;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready_low", 64'(ifc.load_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_high", 64'(ifc.load_ready), 64'd1);

        run(64'hA5, 8, 1'b0, 0, "t1_msb");
        run(64'h3, 4, 1'b1, 2, "t2_lsb_rep");
        run(64'hFFFF, 0, 1'b0, 0, "t3_len0");
        run({64{1'b1}}, 70, 1'b0, 0, "t4_clamp");
        run({$urandom, $urandom}, 64, 1'b0, 1, "t4b_full_msb");
        run(64'h1, 1, 1'b1, 255, "t4c_max_rep");

        // Abort while the third bit is on out.
        d0 = done_cnt;
        push_exp(64'hB3C5, 16, 1'b0, 0, 3);
        accept(64'hB3C5, 16, 1'b0, 0, "t5_abort");
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_out", 64'(out), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Abort together with load_valid in IDLE.
        abort          = 1'b1;
        ifc.load_valid = 1'b1;
        ifc.load_data  = 64'hA5;
        ifc.load_len   = 7'd8;
        #1;
        chk("t5b_ready", 64'(ifc.load_ready), 64'd0);
        @(negedge clk);
        chk("t5b_busy", 64'(busy), 64'd0);
        chk("t5b_out_valid", 64'(out_valid), 64'd0);
        abort          = 1'b0;
        ifc.load_valid = 1'b0;
        @(negedge clk);
        chk("t5b_busy_later", 64'(busy), 64'd0);

        // Reset mid-pattern, then a clean replay of the first pattern.
        d0 = done_cnt;
        push_exp(64'hA5, 8, 1'b0, 0, 3);
        accept(64'hA5, 8, 1'b0, 0, "t6_rst");
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out", 64'(out), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        run(64'hA5, 8, 1'b0, 0, "t6_replay");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
